csr_file: RTL
=============

// Module: csr_file
// PURPOSE
//  Machine-mode CSR register file for the RV32 core: the storage end of the CSR datapath.
//  - csr_rdata feeds the CSR ALU's csr operand.
//  - The CSR ALU result returns on csr_wdata.
//  - Also owns trap entry/mret state update, interrupt gating and the 64-bit cycle/instret counters.
// PARAMETERS
//  RESET_MTVEC  32'h0000_0000  mtvec value after reset
//  HART_ID      32'd0          value returned by mhartid (0xF14)
// PORTS
//  clk          in   1   single clock; all state updates on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  csr_addr     in   12  CSR address, read and write
//  csr_rdata    out  32  combinational read data for csr_addr (0 if unmapped)
//  csr_we       in   1   write csr_wdata to csr_addr this edge
//  csr_wdata    in   32  new CSR value from CSR ALU
//  csr_illegal  out  1   comb: csr_addr unmapped, or csr_we to read-only CSR (addr[11:10]==2'b11)
//  instret      in   1   one instruction retired this cycle
//  trap_valid   in   1   one-cycle pulse: take trap this edge
//  trap_cause   in   32  mcause value; bit31 = interrupt
//  trap_pc      in   32  PC saved to mepc
//  trap_tval    in   32  value saved to mtval
//  mret         in   1   one-cycle pulse: return from trap
//  ext_irq      in   1   external interrupt level (mip.MEIP, bit 11)
//  timer_irq    in   1   timer interrupt level (mip.MTIP, bit 7)
//  trap_vector  out  32  comb: handler PC for current trap_cause
//  mepc_o       out  32  current mepc (mret target)
//  irq_req      out  1   registered: mstatus.MIE & |(mie & mip)
// BEHAVIOUR
//  Map (all other addresses illegal, read 0, writes ignored):
//   - 0x300 mstatus: MIE bit3, MPIE bit7; MPP[12:11] reads 2'b11; other bits read 0.
//   - 0x301 misa: RO 0x4000_0100. 0x304 mie: bits 11,7 writable. 0x305 mtvec: bits[1:0] WARL, only 00/01 kept.
//   - 0x340 mscratch; 0x341 mepc: bits[1:0] forced 0; 0x342 mcause; 0x343 mtval.
//   - 0x344 mip: read-only, {ext_irq@11, timer_irq@7}.
//   - 0xB00/0xB80 mcycle lo/hi; 0xB02/0xB82 minstret lo/hi (RW).
//   - 0xC00/0xC80/0xC02/0xC82: RO mirrors. 0xF14 mhartid: RO HART_ID.
//  Reset (async, rst_n=0): all registers 0, mtvec=RESET_MTVEC, irq_req=0.
//   - Reset mid-trap or mid-write discards the update.
//  Read: zero latency, combinational. Write: visible on csr_rdata the cycle after the edge.
//  Priority in same cycle: trap_valid > mret > csr_we. The lower-priority event is dropped entirely.
//   - The lone exception is counters: a csr_we to a counter always applies, even alongside trap/mret.
//  Trap entry: mepc<=trap_pc&~3, mcause<=trap_cause, mtval<=trap_tval, MPIE<=MIE, MIE<=0.
//  mret: MIE<=MPIE, MPIE<=1; mepc unchanged.
//  trap_vector:
//   - Default: {mtvec[31:2],2'b00}.
//   - If mtvec[1:0]==01 and trap_cause[31]: base + {trap_cause[4:0],2'b00}.
//  Counters:
//   - 64-bit; mcycle += 1 every cycle; minstret += instret.
//   - Carry lo->hi; wrap 2^64-1 -> 0.
//   - csr_we to lo or hi half replaces that half; that cycle's increment is suppressed for the whole counter.
//  irq_req: registered one cycle after the inputs. Deasserts the cycle after MIE clears (e.g. trap entry).
// CONFIGURATION
//  CSR_COUNTERS_EN
//   - Defined: counters, mirrors and instret logic exist as above.
//   - Undefined: no counter flops; 0xB00/0xB02/0xB80/0xB82/0xC00/0xC02/0xC80/0xC82 are unmapped.
//     They read 0 and assert csr_illegal; instret is ignored.
// TESTING
//  1. Release reset -> read 0x305=RESET_MTVEC, 0x300=0x1800, irq_req=0; write 0x340=0xDEADBEEF -> next-cycle read 0xDEADBEEF.
//  2. MIE=1, mie=0x800, ext_irq=1 -> irq_req=1 one cycle later.
//     Then trap_valid(cause 0x8000000B, pc 0x104) -> mepc=0x104, mstatus=0x1880, irq_req=0 next cycle.
//     Then mret -> mstatus=0x1888.
//  3. mtvec=0x1001, trap_cause=0x80000007 -> trap_vector=0x101C; trap_cause=0x2 -> trap_vector=0x1000.
//  4. Write mcycle lo=0xFFFFFFFF, hi=0xFFFFFFFF -> next read 0xFFFFFFFF/FFFFFFFF; one cycle later both halves read 0 (wrap).
//  5. Same-cycle trap_valid+csr_we to 0x341 -> mepc=trap_pc. csr_we to 0xC00 or 0x999 -> csr_illegal=1, no state change.
//  6. Build without CSR_COUNTERS_EN -> read 0xB00 = 0, csr_illegal=1; pulse instret 5x -> no change.

Source files
------------

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR register file for the RV32 core.
// Holds mstatus/mie/mtvec/mscratch/mepc/mcause/mtval, decodes the CSR
// address map, applies trap entry and mret updates, gates interrupts into
// a registered irq_req and computes the trap handler vector.
// Optional feature macro: CSR_COUNTERS_EN adds the 64-bit mcycle/minstret
// counters and their read-only mirrors; without it those addresses are
// unmapped and instret is ignored.
module csr_file #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] csr_addr,
    output logic [31:0] csr_rdata,
    input  logic        csr_we,
    input  logic [31:0] csr_wdata,
    output logic        csr_illegal,
    input  logic        instret,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        mret,
    input  logic        ext_irq,
    input  logic        timer_irq,
    output logic [31:0] trap_vector,
    output logic [31:0] mepc_o,
    output logic        irq_req
);

    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

    // architectural state
    logic        mstatus_mie_r;
    logic        mstatus_mpie_r;
    logic        mie_meie_r;
    logic        mie_mtie_r;
    logic [31:0] mtvec_r;
    logic [31:0] mscratch_r;
    logic [31:0] mepc_r;
    logic [31:0] mcause_r;
    logic [31:0] mtval_r;
    logic        irq_req_r;

    // decoded views
    logic [31:0] mstatus_s;
    logic [31:0] mie_s;
    logic [31:0] mip_s;
    logic        mapped_s;
    logic        read_only_s;
    logic        sw_we_s;
    logic [31:0] vector_base_s;
    logic        irq_pending_s;

    assign read_only_s = (csr_addr[11:10] == 2'b11);
    // a software write to non-counter state loses to trap entry and mret
    assign sw_we_s     = csr_we & ~read_only_s & ~trap_valid & ~mret;

    assign mstatus_s = {19'd0, 2'b11, 3'd0, mstatus_mpie_r, 3'd0, mstatus_mie_r, 3'd0};
    assign mie_s     = {20'd0, mie_meie_r, 3'd0, mie_mtie_r, 7'd0};
    assign mip_s     = {20'd0, ext_irq, 3'd0, timer_irq, 7'd0};

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_r;
    logic [63:0] minstret_r;
    logic        cyc_lo_we_s;
    logic        cyc_hi_we_s;
    logic        ret_lo_we_s;
    logic        ret_hi_we_s;

    // counter writes are never blocked by trap or mret
    assign cyc_lo_we_s = csr_we & (csr_addr == 12'hB00);
    assign cyc_hi_we_s = csr_we & (csr_addr == 12'hB80);
    assign ret_lo_we_s = csr_we & (csr_addr == 12'hB02);
    assign ret_hi_we_s = csr_we & (csr_addr == 12'hB82);

    // mcycle: free-running 64-bit count, a half-write replaces that half and skips the increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle_r <= 64'd0;
        end else if (cyc_lo_we_s) begin
            mcycle_r[31:0] <= csr_wdata;
        end else if (cyc_hi_we_s) begin
            mcycle_r[63:32] <= csr_wdata;
        end else begin
            mcycle_r <= mcycle_r + 64'd1;
        end
    end

    // minstret: counts retired instructions, same write/suppress rule as mcycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            minstret_r <= 64'd0;
        end else if (ret_lo_we_s) begin
            minstret_r[31:0] <= csr_wdata;
        end else if (ret_hi_we_s) begin
            minstret_r[63:32] <= csr_wdata;
        end else if (instret) begin
            minstret_r <= minstret_r + 64'd1;
        end else begin
            minstret_r <= minstret_r;
        end
    end
`else
    logic unused_instret_s;
    assign unused_instret_s = instret;
`endif

    // address decode and combinational read mux
    always_comb begin
        csr_rdata = 32'd0;
        mapped_s  = 1'b1;
        case (csr_addr)
            12'h300: csr_rdata = mstatus_s;
            12'h301: csr_rdata = MISA_VALUE;
            12'h304: csr_rdata = mie_s;
            12'h305: csr_rdata = mtvec_r;
            12'h340: csr_rdata = mscratch_r;
            12'h341: csr_rdata = mepc_r;
            12'h342: csr_rdata = mcause_r;
            12'h343: csr_rdata = mtval_r;
            12'h344: csr_rdata = mip_s;
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hC00: csr_rdata = mcycle_r[31:0];
            12'hB80, 12'hC80: csr_rdata = mcycle_r[63:32];
            12'hB02, 12'hC02: csr_rdata = minstret_r[31:0];
            12'hB82, 12'hC82: csr_rdata = minstret_r[63:32];
`endif
            12'hF14: csr_rdata = HART_ID;
            default: begin
                csr_rdata = 32'd0;
                mapped_s  = 1'b0;
            end
        endcase
    end

    assign csr_illegal = ~mapped_s | (csr_we & read_only_s);

    // mstatus: trap entry stacks MIE, mret unstacks it, otherwise software write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie_r  <= 1'b0;
            mstatus_mpie_r <= 1'b0;
        end else if (trap_valid) begin
            mstatus_mpie_r <= mstatus_mie_r;
            mstatus_mie_r  <= 1'b0;
        end else if (mret) begin
            mstatus_mie_r  <= mstatus_mpie_r;
            mstatus_mpie_r <= 1'b1;
        end else if (sw_we_s && (csr_addr == 12'h300)) begin
            mstatus_mie_r  <= csr_wdata[3];
            mstatus_mpie_r <= csr_wdata[7];
        end else begin
            mstatus_mie_r  <= mstatus_mie_r;
            mstatus_mpie_r <= mstatus_mpie_r;
        end
    end

    // trap CSRs: trap entry overrides any software write in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mepc_r   <= 32'd0;
            mcause_r <= 32'd0;
            mtval_r  <= 32'd0;
        end else if (trap_valid) begin
            mepc_r   <= {trap_pc[31:2], 2'b00};
            mcause_r <= trap_cause;
            mtval_r  <= trap_tval;
        end else if (sw_we_s) begin
            case (csr_addr)
                12'h341: mepc_r   <= {csr_wdata[31:2], 2'b00};
                12'h342: mcause_r <= csr_wdata;
                12'h343: mtval_r  <= csr_wdata;
                default: mepc_r   <= mepc_r;
            endcase
        end else begin
            mepc_r <= mepc_r;
        end
    end

    // software-only configuration CSRs: mie, mtvec, mscratch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_meie_r <= 1'b0;
            mie_mtie_r <= 1'b0;
            mtvec_r    <= RESET_MTVEC;
            mscratch_r <= 32'd0;
        end else if (sw_we_s) begin
            case (csr_addr)
                12'h304: begin
                    mie_meie_r <= csr_wdata[11];
                    mie_mtie_r <= csr_wdata[7];
                end
                12'h305: begin
                    mtvec_r[31:2] <= csr_wdata[31:2];
                    // only direct (00) and vectored (01) modes are kept
                    if (csr_wdata[1] == 1'b0) begin
                        mtvec_r[1:0] <= csr_wdata[1:0];
                    end else begin
                        mtvec_r[1:0] <= mtvec_r[1:0];
                    end
                end
                12'h340: mscratch_r <= csr_wdata;
                default: mscratch_r <= mscratch_r;
            endcase
        end else begin
            mscratch_r <= mscratch_r;
        end
    end

    assign irq_pending_s = mstatus_mie_r & (|(mie_s & mip_s));

    // irq_req: registered copy of the enabled-and-pending interrupt condition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_req_r <= 1'b0;
        end else begin
            irq_req_r <= irq_pending_s;
        end
    end

    assign irq_req = irq_req_r;
    assign mepc_o  = mepc_r;

    // handler PC: vectored mode offsets interrupts by 4*cause
    always_comb begin
        vector_base_s = {mtvec_r[31:2], 2'b00};
        if ((mtvec_r[1:0] == 2'b01) && trap_cause[31]) begin
            trap_vector = vector_base_s + {25'd0, trap_cause[4:0], 2'b00};
        end else begin
            trap_vector = vector_base_s;
        end
    end

endmodule
